nubus_mem_arbiter: RTL

//  Shares one local memory port between the NuBus slave controller (S port) and the
//  on-card local CPU (C port). S normally has priority; a starvation counter keeps C

---
 rtl/nubus_pkg.sv | 19 +
 rtl/nubus_wdog_counter.sv | 29 ++
 rtl/nubus_mem_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/nubus_pkg.sv
// Shared NuBus card definitions: arbiter state encodings, default timing limits
// and the memory request bundle carried from a requester onto the memory port.
package nubus_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_S = 2'd1;
    localparam logic [1:0] ARB_BUSY_C = 2'd2;

    localparam int DEF_TIMEOUT      = 255;
    localparam int DEF_TIMEOUT_W    = 8;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  write;
    } mem_req_t;

endpackage

// File: rtl/nubus_wdog_counter.sv
// Access watchdog: counts enabled cycles from a clear and flags the cycle in which
// the count reaches LIMIT-1. Holds at that value until cleared.
module nubus_wdog_counter #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Shares the card memory port between the NuBus slave (S) and the local CPU (C).
// S wins ties unless C has lost STARVE_LIMIT ties in a row; a watchdog error-acks hung accesses.
module nubus_mem_arbiter
    import nubus_pkg::*;
#(
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int TIMEOUT_W    = DEF_TIMEOUT_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        nub_clkn,
    input  logic        reset,
    input  logic        s_valid,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_write,
    output logic        s_ready,
    output logic        s_err,
    output logic [31:0] s_rdata,
    input  logic        c_valid,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_write,
    output logic        c_ready,
    output logic        c_err,
    output logic [31:0] c_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_write,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic        grant_s,
    output logic        grant_c
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       idle;
    logic       start;
    logic       pick_c;
    logic       done;
    logic       wd_expired;
    mem_req_t   win_req;

    assign idle   = (state == ARB_IDLE);
    assign start  = idle && (s_valid || c_valid);
    assign pick_c = c_valid && (!s_valid || starve_cnt == STARVE_MAX);
    assign done   = !idle && (m_ready || wd_expired);

    // NOTE: every branch assigns win_req, so this stays purely combinational (no latch).
    always_comb begin
        if (pick_c) begin
            win_req = '{addr: c_addr, wdata: c_wdata, write: c_write};
        end else begin
            win_req = '{addr: s_addr, wdata: s_wdata, write: s_write};
        end
    end

    always_ff @(posedge nub_clkn) begin
        if (reset) begin
            state      <= ARB_IDLE;
            m_valid    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_write    <= '0;
            starve_cnt <= '0;
        end else begin
            if (start) begin
                state   <= pick_c ? ARB_BUSY_C : ARB_BUSY_S;
                m_valid <= 1'b1;
                m_addr  <= win_req.addr;
                m_wdata <= win_req.wdata;
                m_write <= win_req.write;
            end else if (done) begin
                state   <= ARB_IDLE;
                m_valid <= 1'b0;
            end

            // Counts S wins that C sat through; any gap in C's request forgives the debt.
            if (!c_valid || (start && pick_c)) begin
                starve_cnt <= '0;
            end else if (start && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    nubus_wdog_counter #(
        .W     (TIMEOUT_W),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk     (nub_clkn),
        .reset   (reset),
        .clear   (idle),
        .enable  (!idle),
        .expired (wd_expired)
    );

    assign grant_s = (state == ARB_BUSY_S);
    assign grant_c = (state == ARB_BUSY_C);

    // A memory ack on the timeout cycle counts as a normal completion.
    assign s_ready = grant_s && (m_ready || wd_expired);
    assign s_err   = grant_s && wd_expired && !m_ready;
    assign c_ready = grant_c && (m_ready || wd_expired);
    assign c_err   = grant_c && wd_expired && !m_ready;

    assign s_rdata = m_rdata;
    assign c_rdata = m_rdata;

endmodule
